key_schedule_ctrl: RTL and testbench

- Sequencer directly upstream of the F-function key-expansion stage.
- Accepts a 128-bit AES-128 cipher key and drives the F stage round by round. For each round it supplies the last word of the previous round key, that key itself, and the round constant.
- Captures each returned round key into an 11-entry round-key store.
- Exposes the store through a registered read port to the cipher datapath.

---
 rtl/aes_key_pkg.sv | 21 ++
 rtl/round_key_store.sv | 63 ++++++
 rtl/key_schedule_ctrl.sv | 153 +++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// Shared types and helpers for the AES-128 key-schedule sequencer.
package aes_key_pkg;

    localparam int ROUND_KEY_W = 128;
    localparam int WORD_W      = 32;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STORE,
        ST_DONE,
        ST_ERROR
    } key_sched_state_e;

    // GF(2^8) multiply-by-two, used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/round_key_store.sv
// Round-key register file: one write port, one registered read port,
// per-entry valid bits that can be cleared together.
module round_key_store #(
    parameter int NUM_ENTRIES = 11,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

    logic [DATA_W-1:0]      mem [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [NUM_ENTRIES-1:0] valid_d;
    logic                   waddr_ok;
    logic                   raddr_ok;

    assign waddr_ok = (waddr_i <= LAST_ADDR);
    assign raddr_ok = (raddr_i <= LAST_ADDR);

    // Clear-all applies first so a simultaneous write leaves only its own bit set.
    always_comb begin
        valid_d = clr_i ? '0 : valid_q;
        if (we_i && waddr_ok) begin
            valid_d[waddr_i] = 1'b1;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (we_i && waddr_ok) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Valid bits and registered read port (same-cycle writes are not forwarded).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (raddr_ok) begin
                rdata_o  <= mem[raddr_i];
                rvalid_o <= valid_q[raddr_i];
            end else begin
                rdata_o  <= '0;
                rvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: drives the F stage round by round and
// collects the returned round keys into a readable store.
module key_schedule_ctrl
    import aes_key_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int F_TIMEOUT  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ROUND_KEY_W-1:0] key_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   f_en_o,
    output logic [WORD_W-1:0]      f_word_o,
    output logic [7:0]             f_rcon_o,
    output logic [ROUND_KEY_W-1:0] f_key_prev_o,
    input  logic                   f_done_i,
    input  logic [ROUND_KEY_W-1:0] f_key_i,
    input  logic [3:0]             rk_addr_i,
    output logic [ROUND_KEY_W-1:0] rk_data_o,
    output logic                   rk_valid_o
);

    localparam int TMO_W = $clog2(F_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(F_TIMEOUT - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);

    key_sched_state_e       state_q, state_d;
    logic [3:0]             round_q;
    logic [7:0]             rcon_q;
    logic [ROUND_KEY_W-1:0] prev_q;
    logic [ROUND_KEY_W-1:0] cap_q;
    logic [TMO_W-1:0]       tmo_q;

    logic                   load;
    logic                   capture;
    logic                   advance;
    logic                   st_we;
    logic                   st_clr;
    logic [3:0]             st_addr;
    logic [ROUND_KEY_W-1:0] st_wdata;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, F-stage request outputs and store write control.
    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        f_en_o       = 1'b0;
        f_word_o     = '0;
        f_rcon_o     = '0;
        f_key_prev_o = '0;
        load         = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        st_we        = 1'b0;
        st_clr       = 1'b0;
        st_addr      = round_q;
        st_wdata     = cap_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                done_o = (state_q == ST_DONE);
                err_o  = (state_q == ST_ERROR);
                if (start_i) begin
                    load     = 1'b1;
                    st_we    = 1'b1;
                    st_clr   = 1'b1;
                    st_addr  = '0;
                    st_wdata = key_i;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy_o       = 1'b1;
                f_en_o       = 1'b1;
                f_word_o     = prev_q[WORD_W-1:0];
                f_key_prev_o = prev_q;
                f_rcon_o     = rcon_q;
                if (f_done_i) begin
                    capture = 1'b1;
                    state_d = ST_STORE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_STORE: begin
                busy_o  = 1'b1;
                st_we   = 1'b1;
                advance = 1'b1;
                state_d = (round_q == LAST_ROUND) ? ST_DONE : ST_ISSUE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Round datapath: previous key, captured key, rcon, round and timeout counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q  <= '0;
            cap_q   <= '0;
            rcon_q  <= RCON_INIT;
            round_q <= '0;
            tmo_q   <= '0;
        end else begin
            if (state_q == ST_ISSUE) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (capture) begin
                cap_q <= f_key_i;
            end
            if (load) begin
                prev_q  <= key_i;
                rcon_q  <= RCON_INIT;
                round_q <= 4'd1;
                tmo_q   <= '0;
            end else if (advance) begin
                prev_q  <= cap_q;
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
                tmo_q   <= '0;
            end
        end
    end

    round_key_store #(
        .NUM_ENTRIES(NUM_ROUNDS + 1),
        .ADDR_W     (4),
        .DATA_W     (ROUND_KEY_W)
    ) u_store (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (st_we),
        .waddr_i (st_addr),
        .wdata_i (st_wdata),
        .clr_i   (st_clr),
        .raddr_i (rk_addr_i),
        .rdata_o (rk_data_o),
        .rvalid_o(rk_valid_o)
    );

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl with a behavioural F-stage model.
module tb_key_schedule_ctrl;

    localparam int NR = 10;
    localparam int TO = 64;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         busy_o, done_o, err_o, f_en_o;
    logic [31:0]  f_word_o;
    logic [7:0]   f_rcon_o;
    logic [127:0] f_key_prev_o;
    logic         f_done_i = 1'b0;
    logic [127:0] f_key_i = '0;
    logic [3:0]   rk_addr_i = '0;
    logic [127:0] rk_data_o;
    logic         rk_valid_o;

    key_schedule_ctrl #(.NUM_ROUNDS(NR), .F_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .key_i(key_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .f_en_o(f_en_o), .f_word_o(f_word_o), .f_rcon_o(f_rcon_o),
        .f_key_prev_o(f_key_prev_o), .f_done_i(f_done_i), .f_key_i(f_key_i),
        .rk_addr_i(rk_addr_i), .rk_data_o(rk_data_o), .rk_valid_o(rk_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // FIPS-197 appendix A.1 expansion of 2b7e1516..., one 128-bit round key per entry.
    logic [127:0] fips [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // Model state: keys the F stage will return, per-round latency, progress.
    logic [127:0] exp_rk [11];
    int           lat [11];
    int           mround = 0;
    bit           f_hang = 1'b0;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
        logic         valid;
    } rd_vec_t;
    rd_vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // F-stage model: answers round r with exp_rk[r] after lat[r] request cycles.
    initial begin
        int fcnt = 0;
        forever begin
            @(negedge clk_i);
            if (f_en_o && !f_hang && mround < NR) begin
                fcnt++;
                if (fcnt == lat[mround + 1]) begin
                    mround++;
                    chk("f_key_prev", f_key_prev_o, exp_rk[mround - 1]);
                    chk("f_word", f_word_o, exp_rk[mround - 1][31:0]);
                    chk("f_rcon", f_rcon_o, rcon_tab[mround - 1]);
                    f_done_i = 1'b1;
                    f_key_i  = exp_rk[mround];
                end else begin
                    f_done_i = 1'b0;
                end
            end else begin
                fcnt     = 0;
                f_done_i = 1'b0;
            end
        end
    end

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d, output logic v);
        rk_addr_i = a;
        @(negedge clk_i);
        d = rk_data_o;
        v = rk_valid_o;
    endtask

    task automatic start_exp(input logic [127:0] k);
        mround  = 0;
        key_i   = k;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Waits for done/err; optionally pulses a stray start while busy.
    task automatic wait_end(input int cyc0, input int glitch_at, output int cyc);
        cyc = cyc0;
        while (!done_o && !err_o && cyc < 400) begin
            if (cyc == glitch_at) begin
                start_i = 1'b1;
                key_i   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk_i);
            start_i = 1'b0;
            cyc++;
        end
    endtask

    function automatic int exp_cycles();
        int c = 1;
        for (int r = 1; r <= NR; r++) c += lat[r] + 1;
        return c;
    endfunction

    task automatic verify_store();
        logic [127:0] d;
        logic         v;
        for (int i = 0; i <= NR; i++) begin
            read_rk(4'(i), d, v);
            chk("store_data", d, exp_rk[i]);
            chk("store_valid", v, 1'b1);
        end
    endtask

    task automatic run_full(input int glitch_at);
        int cyc;
        int want;
        want = exp_cycles();
        start_exp(exp_rk[0]);
        chk("busy_after_start", busy_o, 1'b1);
        wait_end(1, glitch_at, cyc);
        chk("done", done_o, 1'b1);
        chk("err_clear", err_o, 1'b0);
        chk("busy_done", busy_o, 1'b0);
        chk("done_cycles", 128'(cyc), 128'(want));
        verify_store();
    endtask

    task automatic rand_setup();
        for (int i = 0; i <= NR; i++) exp_rk[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 1; r <= NR; r++) lat[r] = int'($urandom_range(1, 5));
    endtask

    initial begin
        logic [127:0] d;
        logic         v;
        int           cyc;

        // Reset values
        #2 rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_f_en", f_en_o, 1'b0);
        chk("rst_f_word", f_word_o, 32'h0);
        chk("rst_f_rcon", f_rcon_o, 8'h0);
        chk("rst_f_key_prev", f_key_prev_o, 128'h0);
        chk("rst_rk_data", rk_data_o, 128'h0);
        chk("rst_rk_valid", rk_valid_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // FIPS-197 key, 3-cycle F latency: 41 cycles to done
        for (int i = 0; i <= NR; i++) exp_rk[i] = fips[i];
        for (int r = 1; r <= NR; r++) lat[r] = 3;
        run_full(0);

        vecs[0] = '{4'd0,  fips[0],  1'b1};
        vecs[1] = '{4'd1,  fips[1],  1'b1};
        vecs[2] = '{4'd5,  fips[5],  1'b1};
        vecs[3] = '{4'd10, fips[10], 1'b1};
        vecs[4] = '{4'd11, 128'h0,   1'b0};
        vecs[5] = '{4'd15, 128'h0,   1'b0};
        for (int i = 0; i < 6; i++) begin
            read_rk(vecs[i].addr, d, v);
            chk("vec_data", d, vecs[i].data);
            chk("vec_valid", v, vecs[i].valid);
        end

        // Restart from DONE: done clears next cycle, entry 0 replaced
        rand_setup();
        start_exp(exp_rk[0]);
        chk("done_cleared", done_o, 1'b0);
        read_rk(4'd0, d, v);
        chk("entry0_new", d, exp_rk[0]);
        chk("entry0_valid", v, 1'b1);
        read_rk(4'd1, d, v);
        chk("entry1_cleared", v, 1'b0);
        wait_end(3, -1, cyc);
        chk("restart_done", done_o, 1'b1);
        chk("restart_cycles", 128'(cyc), 128'(exp_cycles()));
        verify_store();

        // Random keys and latencies, with a stray start while busy
        for (int n = 0; n < 3; n++) begin
            rand_setup();
            run_full(7 + n * 5);
        end

        // F stage never answers: timeout after TO cycles in ISSUE
        rand_setup();
        f_hang = 1'b1;
        start_exp(exp_rk[0]);
        wait_end(1, -1, cyc);
        chk("tmo_err", err_o, 1'b1);
        chk("tmo_done", done_o, 1'b0);
        chk("tmo_busy", busy_o, 1'b0);
        chk("tmo_f_en", f_en_o, 1'b0);
        chk("tmo_cycles", 128'(cyc), 128'(TO + 1));
        read_rk(4'd0, d, v);
        chk("tmo_entry0", d, exp_rk[0]);
        chk("tmo_valid0", v, 1'b1);
        read_rk(4'd1, d, v);
        chk("tmo_valid1", v, 1'b0);
        f_hang = 1'b0;

        // Reset during round 5, then a clean expansion
        for (int i = 0; i <= NR; i++) exp_rk[i] = fips[i];
        for (int r = 1; r <= NR; r++) lat[r] = 2;
        start_exp(exp_rk[0]);
        cyc = 0;
        while (mround < 4 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("reached_round5", 128'(mround), 128'd4);
        repeat (3) @(negedge clk_i);
        chk("pre_rst_f_en", f_en_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_f_en", f_en_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_f_word", f_word_o, 32'h0);
        chk("mid_rst_f_rcon", f_rcon_o, 8'h0);
        chk("mid_rst_f_key_prev", f_key_prev_o, 128'h0);
        chk("mid_rst_rk_valid", rk_valid_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        read_rk(4'd0, d, v);
        chk("post_rst_valid0", v, 1'b0);
        read_rk(4'd3, d, v);
        chk("post_rst_valid3", v, 1'b0);
        run_full(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
